dma_device_port: RTL and testbench

- Device-side initiator for the DMA controller's device interface.
- Owns a local word buffer and accepts transfer commands from a local host (peripheral logic or CPU-side register block).
- Drives rqst, num_words, start_addr and rd_wr, and exchanges words with the controller via the dev_ack/dma_ack handshake until end_flag.
- Read direction (memory to buffer) and write direction (buffer to memory) are both supported.

---
 rtl/dma_device_port_if.sv | 26 ++
 rtl/dma_device_port.sv | 143 ++++++++++++++
 tb/tb_dma_device_port.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_device_port_if.sv
// Handshake bundle between a device-side DMA initiator (master) and the DMA controller (slave).
`timescale 1ns/1ps
interface dma_device_port_if #(
   parameter int unsigned ADD_LEN  = 16,
   parameter int unsigned DATA_LEN = 16
) ();
   logic                rqst;
   logic [ADD_LEN-1:0]  num_words;
   logic [ADD_LEN:0]    start_addr;
   logic                rd_wr;
   logic                dev_ack;
   logic [DATA_LEN-1:0] dev_out;
   logic [DATA_LEN-1:0] dev_in;
   logic                dma_ack;
   logic                end_flag;

   modport master (
      output rqst, num_words, start_addr, rd_wr, dev_ack, dev_out,
      input  dev_in, dma_ack, end_flag
   );

   modport slave (
      input  rqst, num_words, start_addr, rd_wr, dev_ack, dev_out,
      output dev_in, dma_ack, end_flag
   );
endinterface

// File: rtl/dma_device_port.sv
// Device-side DMA initiator: local word buffer, command validation, and word-by-word
// exchange with the DMA controller in either direction, with timeout and error reporting.
`timescale 1ns/1ps
module dma_device_port #(
   parameter int unsigned ADD_LEN   = 16,
   parameter int unsigned DATA_LEN  = 16,
   parameter int unsigned BUF_DEPTH = 5,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_start_i,
   input  logic                 cmd_rd_wr_i,
   input  logic [ADD_LEN:0]     cmd_addr_i,
   input  logic [ADD_LEN-1:0]   cmd_words_i,
   input  logic                 xfer_en_i,
   input  logic [BUF_DEPTH-1:0] buf_addr_i,
   input  logic                 buf_we_i,
   input  logic [DATA_LEN-1:0]  buf_wdata_i,
   output logic [DATA_LEN-1:0]  buf_rdata_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [ADD_LEN-1:0]   xfer_count_o,
   dma_device_port_if.master    dma
);
   localparam int unsigned PtrW     = BUF_DEPTH + 1;
   localparam int unsigned BufWords = 2 ** BUF_DEPTH;
   localparam int unsigned TmoW     = $clog2(TIMEOUT + 1);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StCheck = 3'd1;
   localparam logic [2:0] StReq   = 3'd2;
   localparam logic [2:0] StXfer  = 3'd3;
   localparam logic [2:0] StDone  = 3'd4;
   localparam logic [2:0] StErr   = 3'd5;

   logic [2:0]          state_q, state_d;
   logic [PtrW-1:0]     ptr_q, ptr_d;
   logic [ADD_LEN-1:0]  num_words_q, num_words_d;
   logic [ADD_LEN:0]    start_addr_q, start_addr_d;
   logic                rd_wr_q, rd_wr_d;
   logic                err_q, err_d;
   logic [TmoW-1:0]     tmo_q, tmo_d;
   logic [DATA_LEN-1:0] buf_q [BufWords];

   logic               in_xfer, room, accept;
   logic [ADD_LEN-1:0] ptr_ext, ptr_after;

   assign in_xfer   = (state_q == StXfer);
   assign ptr_ext   = ADD_LEN'(ptr_q);
   assign room      = (ptr_ext < num_words_q);
   // dma_ack is honoured even if xfer_en just dropped: the controller may have committed the word.
   assign accept    = in_xfer & dma.dma_ack & room;
   assign ptr_after = ptr_ext + ADD_LEN'(accept);

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      num_words_d  = num_words_q;
      start_addr_d = start_addr_q;
      rd_wr_d      = rd_wr_q;
      err_d        = err_q;
      tmo_d        = '0;
      case (state_q)
         StIdle: begin
            if (cmd_start_i) begin
               num_words_d  = cmd_words_i;
               start_addr_d = cmd_addr_i;
               rd_wr_d      = cmd_rd_wr_i;
               err_d        = 1'b0;
               ptr_d        = '0;
               state_d      = StCheck;
            end
         end
         StCheck: begin
            if ((num_words_q > ADD_LEN'(BufWords)) || start_addr_q[0]) state_d = StErr;
            else                                                      state_d = StReq;
         end
         StReq: state_d = StXfer;
         StXfer: begin
            if (accept) ptr_d = ptr_q + PtrW'(1);
            if (dma.dma_ack && !room) err_d = 1'b1;
            if (dma.dma_ack || dma.end_flag) begin
               tmo_d = '0;
            end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
               state_d = StErr;
            end else begin
               tmo_d = tmo_q + TmoW'(1);
            end
            if (dma.end_flag) state_d = (ptr_after == num_words_q) ? StDone : StErr;
         end
         StDone: state_d = StIdle;
         StErr: begin
            err_d   = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= StIdle;
         ptr_q        <= '0;
         num_words_q  <= '0;
         start_addr_q <= '0;
         rd_wr_q      <= 1'b0;
         err_q        <= 1'b0;
         tmo_q        <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         num_words_q  <= num_words_d;
         start_addr_q <= start_addr_d;
         rd_wr_q      <= rd_wr_d;
         err_q        <= err_d;
         tmo_q        <= tmo_d;
      end
   end

   // Buffer storage is deliberately not reset; the DMA path writes only in XFER.
   always_ff @(posedge clk) begin
      if (buf_we_i && (state_q == StIdle)) begin
         buf_q[buf_addr_i] <= buf_wdata_i;
      end else if (accept && rd_wr_q && reset) begin
         buf_q[ptr_q[BUF_DEPTH-1:0]] <= dma.dev_in;
      end
   end

   assign dma.rqst       = (state_q == StReq);
   assign dma.num_words  = num_words_q;
   assign dma.start_addr = start_addr_q;
   assign dma.rd_wr      = rd_wr_q;
   assign dma.dev_ack    = in_xfer & xfer_en_i & room;
   assign dma.dev_out    = buf_q[ptr_q[BUF_DEPTH-1:0]];

   assign buf_rdata_o  = buf_q[buf_addr_i];
   assign busy_o       = (state_q != StIdle);
   assign done_o       = (state_q == StDone);
   assign err_o        = err_q;
   assign xfer_count_o = ptr_ext;
endmodule

// File: tb/tb_dma_device_port.sv
// Directed-plus-random bench for dma_device_port with a behavioural DMA controller and memory.
`timescale 1ns/1ps
module tb_dma_device_port;
   localparam int unsigned AL  = 16;
   localparam int unsigned DL  = 16;
   localparam int unsigned BD  = 5;
   localparam int unsigned TMO = 1024;
   localparam int unsigned BW  = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cmd_start, cmd_rd_wr, xfer_en, buf_we;
   logic [AL:0]   cmd_addr;
   logic [AL-1:0] cmd_words, xfer_count;
   logic [BD-1:0] buf_addr;
   logic [DL-1:0] buf_wdata, buf_rdata;
   logic          busy, done, err;

   always #5 clk = ~clk;

   dma_device_port_if #(.ADD_LEN(AL), .DATA_LEN(DL)) bus ();

   dma_device_port #(.ADD_LEN(AL), .DATA_LEN(DL), .BUF_DEPTH(BD), .TIMEOUT(TMO)) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_start_i  (cmd_start),
      .cmd_rd_wr_i  (cmd_rd_wr),
      .cmd_addr_i   (cmd_addr),
      .cmd_words_i  (cmd_words),
      .xfer_en_i    (xfer_en),
      .buf_addr_i   (buf_addr),
      .buf_we_i     (buf_we),
      .buf_wdata_i  (buf_wdata),
      .buf_rdata_o  (buf_rdata),
      .busy_o       (busy),
      .done_o       (done),
      .err_o        (err),
      .xfer_count_o (xfer_count),
      .dma          (bus)
   );

   int checks = 0;
   int failures = 0;
   int rqst_cnt = 0;
   int done_cnt = 0;
   int r0, d0;
   logic [DL-1:0] cmem [65536];
   logic [DL-1:0] ref_buf [BW];

   always @(negedge clk) begin
      if (bus.rqst) rqst_cnt++;
      if (done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load_buf(input int idx, input logic [DL-1:0] data);
      @(negedge clk);
      buf_addr = BD'(idx);
      buf_wdata = data;
      buf_we = 1'b1;
      ref_buf[idx] = data;
      @(negedge clk);
      buf_we = 1'b0;
   endtask

   task automatic read_buf(input int idx, output logic [DL-1:0] data);
      @(negedge clk);
      buf_addr = BD'(idx);
      #1;
      data = buf_rdata;
   endtask

   // mode 0: xfer_en high; 1: xfer_en toggles every 3 cycles; 2: controller never answers.
   task automatic run_xfer(input logic rw, input logic [AL:0] addr, input logic [AL-1:0] words,
                           input int mode, input int abort_at);
      int k, cyc, base;
      bit active, xphase, sent_end;
      logic [AL-1:0] n;
      r0 = rqst_cnt;
      d0 = done_cnt;
      k = 0; active = 0; xphase = 0; sent_end = 0; n = '0; base = 0;
      @(negedge clk);
      cmd_start = 1'b1; cmd_rd_wr = rw; cmd_addr = addr; cmd_words = words; xfer_en = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      check("err_clear_on_start", err, 0);
      cyc = 0;
      while (busy && cyc < 3000) begin
         if (mode == 1) xfer_en = ((cyc / 3) % 2) == 0;
         #1;
         bus.dma_ack = 1'b0;
         bus.end_flag = 1'b0;
         if (active) xphase = 1;
         if (xphase && mode != 2) begin
            check("dev_ack", bus.dev_ack, (xfer_en && (k < int'(n))));
            if (abort_at >= 0 && k == abort_at) begin
               reset = 1'b0;
               @(negedge clk);
               #1;
               check("abort_busy", busy, 0);
               check("abort_rqst", bus.rqst, 0);
               check("abort_dev_ack", bus.dev_ack, 0);
               reset = 1'b1;
            end else if (k < int'(n)) begin
               if (bus.dev_ack && $urandom_range(3) != 0) begin
                  bus.dma_ack = 1'b1;
                  if (rw) bus.dev_in = cmem[base + k];
                  else    cmem[base + k] = bus.dev_out;
                  k++;
                  if (k == int'(n) && $urandom_range(1) == 1) begin
                     bus.end_flag = 1'b1;
                     sent_end = 1;
                  end
               end
            end else if (!sent_end) begin
               bus.end_flag = 1'b1;
               sent_end = 1;
            end
         end
         if (bus.rqst && !active) begin
            active = 1;
            n = bus.num_words;
            base = int'(bus.start_addr >> 1);
            check("start_addr_held", bus.start_addr, addr);
            check("num_words_held", bus.num_words, words);
            check("rd_wr_held", bus.rd_wr, rw);
         end
         @(negedge clk);
         cyc++;
      end
      bus.dma_ack = 1'b0;
      bus.end_flag = 1'b0;
      check("idle_within_budget", busy, 0);
      @(negedge clk);
   endtask

   logic [DL-1:0] rd;
   int base;
   logic [AL:0] addr;

   initial begin
      cmd_start = 0; cmd_rd_wr = 0; cmd_addr = '0; cmd_words = '0; xfer_en = 0;
      buf_addr = '0; buf_we = 0; buf_wdata = '0;
      bus.dev_in = '0; bus.dma_ack = 0; bus.end_flag = 0;
      for (int i = 0; i < 65536; i++) cmem[i] = '0;

      repeat (3) @(negedge clk);
      check("rst_rqst", bus.rqst, 0);
      check("rst_dev_ack", bus.dev_ack, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_num_words", bus.num_words, 0);
      check("rst_start_addr", bus.start_addr, 0);
      check("rst_rd_wr", bus.rd_wr, 0);
      check("rst_xfer_count", xfer_count, 0);
      reset = 1'b1;

      // Write 4 words buffer -> memory at byte 0x0200 (word 0x100)
      for (int i = 0; i < 4; i++) load_buf(i, DL'(16'h1111 * (i + 1)));
      run_xfer(1'b0, 17'h0200, 16'd4, 0, -1);
      check("wr4_rqst_once", rqst_cnt - r0, 1);
      check("wr4_done_once", done_cnt - d0, 1);
      check("wr4_xfer_count", xfer_count, 4);
      check("wr4_err", err, 0);
      for (int i = 0; i < 4; i++) check("wr4_mem", cmem[16'h100 + i], ref_buf[i]);

      // Full-buffer read of 32 words from byte 0x0400
      for (int i = 0; i < 32; i++) cmem[16'h200 + i] = DL'(16'hA000 + i);
      run_xfer(1'b1, 17'h0400, 16'd32, 0, -1);
      check("rd32_done", done_cnt - d0, 1);
      check("rd32_err", err, 0);
      check("rd32_xfer_count", xfer_count, 32);
      for (int i = 0; i < 32; i++) begin
         read_buf(i, rd);
         check("rd32_buf", rd, DL'(16'hA000 + i));
         ref_buf[i] = DL'(16'hA000 + i);
      end

      // Throttled read of 8 random words from a random even address
      addr = {1'b0, 15'($urandom_range(0, 16'h7F00)), 1'b0};
      base = int'(addr >> 1);
      for (int i = 0; i < 8; i++) cmem[base + i] = DL'($urandom);
      run_xfer(1'b1, addr, 16'd8, 1, -1);
      check("thr_done", done_cnt - d0, 1);
      check("thr_xfer_count", xfer_count, 8);
      for (int i = 0; i < 8; i++) begin
         read_buf(i, rd);
         check("thr_buf", rd, cmem[base + i]);
         ref_buf[i] = cmem[base + i];
      end

      // Illegal commands
      run_xfer(1'b1, 17'h0200, 16'd33, 0, -1);
      check("ill_len_err", err, 1);
      check("ill_len_no_rqst", rqst_cnt - r0, 0);
      check("ill_len_no_done", done_cnt - d0, 0);
      run_xfer(1'b0, 17'h0201, 16'd4, 0, -1);
      check("ill_addr_err", err, 1);
      check("ill_addr_no_rqst", rqst_cnt - r0, 0);

      // Zero-length transfer
      run_xfer(1'b0, 17'h0300, 16'd0, 0, -1);
      check("zero_rqst", rqst_cnt - r0, 1);
      check("zero_done", done_cnt - d0, 1);
      check("zero_xfer_count", xfer_count, 0);
      check("zero_err", err, 0);

      // Random write of 10 words to a random even address
      for (int i = 0; i < 10; i++) load_buf(i, DL'($urandom));
      addr = {1'b0, 15'($urandom_range(0, 16'h7F00)), 1'b0};
      base = int'(addr >> 1);
      run_xfer(1'b0, addr, 16'd10, 0, -1);
      check("rwr_done", done_cnt - d0, 1);
      check("rwr_xfer_count", xfer_count, 10);
      for (int i = 0; i < 10; i++) check("rwr_mem", cmem[base + i], ref_buf[i]);

      // Controller silent: timeout
      run_xfer(1'b1, 17'h0200, 16'd3, 2, -1);
      check("tmo_rqst", rqst_cnt - r0, 1);
      check("tmo_err", err, 1);
      check("tmo_no_done", done_cnt - d0, 0);
      check("tmo_idle", busy, 0);

      // Reset at word 5 of a 16-word write
      for (int i = 0; i < 16; i++) load_buf(i, DL'($urandom));
      run_xfer(1'b0, 17'h0800, 16'd16, 0, 5);
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_err", err, 0);
      check("abort_xfer_count", xfer_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
